// File: rtl/scomp_pkg.sv
// Shared SCOMP constants: bus widths and the loader state encoding.
package scomp_pkg;

    localparam int ADDR_W = 8;   // program memory address width (256 words)
    localparam int WORD_W = 16;  // program memory word width
    localparam int BYTE_W = 8;   // host link byte width
    localparam int CNT_W  = 9;   // word counter, wide enough to hold 256

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_HIGH  = 3'd1,
        ST_LOW   = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERROR = 3'd6
    } scomp_state_t;

endpackage

// File: rtl/scomp_loader.sv
// Byte-stream program loader for the SCOMP processor: receives a word count,
// the program words (high byte first) and a checksum, writes the words into
// program memory and releases the processor from reset if the checksum matches.
module scomp_loader
    import scomp_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_write,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    scomp_state_t      state;
    scomp_state_t      next_state;
    logic [CNT_W-1:0]  word_cnt;
    logic [BYTE_W-1:0] sum;
    // addr_ptr advances when WRITE is left; mem_address only picks it up when
    // the next high byte arrives, so the address stays put for the cycle
    // after the write strobe.
    logic [ADDR_W-1:0] addr_ptr;
    logic              accept;

    assign accept = in_valid & in_ready;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_COUNT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        mem_write  = 1'b0;
        cpu_reset  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            ST_COUNT: begin
                in_ready = 1'b1;
                if (accept) next_state = ST_HIGH;
            end
            ST_HIGH: begin
                in_ready = 1'b1;
                if (accept) next_state = ST_LOW;
            end
            ST_LOW: begin
                in_ready = 1'b1;
                if (accept) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                mem_write  = 1'b1;
                next_state = (word_cnt == 9'd1) ? ST_CHECK : ST_HIGH;
            end
            ST_CHECK: begin
                in_ready = 1'b1;
                if (accept) next_state = (in_data == sum) ? ST_RUN : ST_ERROR;
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
                if (reload) next_state = ST_COUNT;
            end
            ST_ERROR: begin
                load_error = 1'b1;
                if (reload) next_state = ST_COUNT;
            end
            default: next_state = ST_COUNT;
        endcase
    end

    // Datapath: word counter, running checksum, address and data latches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_cnt    <= '0;
            sum         <= '0;
            addr_ptr    <= START_ADDR;
            mem_address <= START_ADDR;
            mem_data    <= '0;
        end else begin
            case (state)
                ST_COUNT: if (accept) begin
                    // A count of zero means a full 256-word image.
                    word_cnt    <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    sum         <= in_data;
                    addr_ptr    <= START_ADDR;
                    mem_address <= START_ADDR;
                end
                ST_HIGH: if (accept) begin
                    mem_data[15:8] <= in_data;
                    sum            <= sum + in_data;
                    mem_address    <= addr_ptr;
                end
                ST_LOW: if (accept) begin
                    mem_data[7:0] <= in_data;
                    sum           <= sum + in_data;
                end
                ST_WRITE: begin
                    word_cnt <= word_cnt - 9'd1;
                    addr_ptr <= addr_ptr + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scomp_loader.sv
// Directed bench for scomp_loader: two instances share all inputs, one with
// START_ADDR=00 and one with START_ADDR=F0 for the address wrap case.
module tb_scomp_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        reload;

    logic        in_ready_a, mem_write_a, cpu_reset_a, load_done_a, load_error_a;
    logic [7:0]  mem_address_a;
    logic [15:0] mem_data_a;
    logic        in_ready_b, mem_write_b, cpu_reset_b, load_done_b, load_error_b;
    logic [7:0]  mem_address_b;
    logic [15:0] mem_data_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr_a[$];
    logic [15:0] wr_data_a[$];
    logic [7:0]  wr_addr_b[$];
    logic [15:0] wr_data_b[$];
    int          stab_bad = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [15:0] prev_data = '0;

    always #5 clock = ~clock;

    scomp_loader #(.START_ADDR(8'h00)) u_a (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .reload(reload), .mem_address(mem_address_a),
        .mem_data(mem_data_a), .mem_write(mem_write_a), .cpu_reset(cpu_reset_a),
        .load_done(load_done_a), .load_error(load_error_a)
    );

    scomp_loader #(.START_ADDR(8'hF0)) u_b (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .reload(reload), .mem_address(mem_address_b),
        .mem_data(mem_data_b), .mem_write(mem_write_b), .cpu_reset(cpu_reset_b),
        .load_done(load_done_b), .load_error(load_error_b)
    );

    // Memory-side monitor: log writes and watch address/data hold after a write.
    always @(negedge clock) begin
        if (prev_we && (mem_address_a !== prev_addr || mem_data_a !== prev_data))
            stab_bad++;
        prev_we   = mem_write_a;
        prev_addr = mem_address_a;
        prev_data = mem_data_a;
        if (mem_write_a === 1'b1) begin
            wr_addr_a.push_back(mem_address_a);
            wr_data_a.push_back(mem_data_a);
        end
        if (mem_write_b === 1'b1) begin
            wr_addr_b.push_back(mem_address_b);
            wr_data_b.push_back(mem_data_b);
        end
    end

    task automatic clear_log();
        wr_addr_a.delete(); wr_data_a.delete();
        wr_addr_b.delete(); wr_data_b.delete();
    endtask

    // Offer one byte and hold it until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready_a !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout byte %h never accepted", b);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reload(input string name);
        reload = 1'b1;
        @(posedge clock); #1;
        reload = 1'b0;
        checks++;
        if (in_ready_a !== 1'b1 || cpu_reset_a !== 1'b1 || load_done_a !== 1'b0 || load_error_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_reload rdy=%b crst=%b done=%b err=%b want 1 1 0 0",
                     name, in_ready_a, cpu_reset_a, load_done_a, load_error_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({in_ready_a, mem_write_a, cpu_reset_a, load_done_a, load_error_a} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_flags got %b want 10100",
                     {in_ready_a, mem_write_a, cpu_reset_a, load_done_a, load_error_a});
        end
        checks++;
        if (mem_address_a !== 8'h00 || mem_data_a !== 16'h0000 || mem_address_b !== 8'hF0) begin
            errors++;
            $display("FAIL reset_bus addr=%h data=%h addr_b=%h want 00 0000 f0",
                     mem_address_a, mem_data_a, mem_address_b);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        clear_log();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h47);
        checks++;
        if (wr_addr_a.size() != 1) begin
            errors++; $display("FAIL basic_count got %0d want 1", wr_addr_a.size());
        end else begin
            checks++;
            if (wr_addr_a[0] !== 8'h00 || wr_data_a[0] !== 16'h1234) begin
                errors++; $display("FAIL basic_word got %h:%h want 00:1234", wr_addr_a[0], wr_data_a[0]);
            end
        end
        checks++;
        if (load_done_a !== 1'b1 || cpu_reset_a !== 1'b0 || in_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_run done=%b crst=%b rdy=%b want 1 0 0", load_done_a, cpu_reset_a, in_ready_a);
        end
        // A byte offered in RUN must not be taken.
        in_data = 8'h55; in_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b0;
        checks++;
        if (load_done_a !== 1'b1) begin
            errors++; $display("FAIL basic_hold done=%b want 1", load_done_a);
        end
        do_reload("basic");
    endtask

    task automatic test_two();
        clear_log();
        reload = 1'b1;  // must be ignored outside RUN/ERROR
        send_byte(8'h02); send_byte(8'h00);
        reload = 1'b0;
        send_byte(8'h05); send_byte(8'h02); send_byte(8'h10); send_byte(8'h19);
        checks++;
        if (wr_addr_a.size() != 2) begin
            errors++; $display("FAIL two_count got %0d want 2", wr_addr_a.size());
        end else begin
            checks++;
            if (wr_addr_a[0] !== 8'h00 || wr_data_a[0] !== 16'h0005 ||
                wr_addr_a[1] !== 8'h01 || wr_data_a[1] !== 16'h0210) begin
                errors++;
                $display("FAIL two_words got %h:%h %h:%h want 00:0005 01:0210",
                         wr_addr_a[0], wr_data_a[0], wr_addr_a[1], wr_data_a[1]);
            end
        end
        checks++;
        if (load_done_a !== 1'b1 || cpu_reset_a !== 1'b0) begin
            errors++; $display("FAIL two_run done=%b crst=%b want 1 0", load_done_a, cpu_reset_a);
        end
        do_reload("two");
    endtask

    task automatic test_error();
        clear_log();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
        checks++;
        if (wr_addr_a.size() != 1 || wr_data_a[0] !== 16'h1234) begin
            errors++; $display("FAIL error_write count=%0d want 1 of 1234", wr_addr_a.size());
        end
        checks++;
        if (load_error_a !== 1'b1 || cpu_reset_a !== 1'b1 || load_done_a !== 1'b0 || in_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL error_state err=%b crst=%b done=%b rdy=%b want 1 1 0 0",
                     load_error_a, cpu_reset_a, load_done_a, in_ready_a);
        end
        do_reload("error");
    endtask

    task automatic test_gappy();
        logic [7:0] s[6];
        s = '{8'h02, 8'h00, 8'h05, 8'h02, 8'h10, 8'h19};
        clear_log();
        stab_bad = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(s[i]);
            @(posedge clock); #1;   // one idle cycle with in_valid low
        end
        checks++;
        if (wr_addr_a.size() != 2) begin
            errors++; $display("FAIL gappy_count got %0d want 2", wr_addr_a.size());
        end else begin
            checks++;
            if (wr_addr_a[0] !== 8'h00 || wr_data_a[0] !== 16'h0005 ||
                wr_addr_a[1] !== 8'h01 || wr_data_a[1] !== 16'h0210) begin
                errors++;
                $display("FAIL gappy_words got %h:%h %h:%h want 00:0005 01:0210",
                         wr_addr_a[0], wr_data_a[0], wr_addr_a[1], wr_data_a[1]);
            end
        end
        checks++;
        if (load_done_a !== 1'b1) begin
            errors++; $display("FAIL gappy_run done=%b want 1", load_done_a);
        end
        checks++;
        if (stab_bad != 0) begin
            errors++; $display("FAIL gappy_stable got %0d unstable cycles want 0", stab_bad);
        end
        do_reload("gappy");
    endtask

    task automatic test_full();
        int bad = 0;
        clear_log();
        send_byte(8'h00);
        for (int i = 0; i < 512; i++) send_byte(8'hFF);
        send_byte(8'h00);
        checks++;
        if (wr_addr_a.size() != 256) begin
            errors++; $display("FAIL full_count got %0d want 256", wr_addr_a.size());
        end else begin
            for (int i = 0; i < 256; i++)
                if (wr_addr_a[i] !== 8'(i) || wr_data_a[i] !== 16'hFFFF) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL full_words got %0d bad entries want 0", bad);
            end
        end
        checks++;
        if (load_done_a !== 1'b1) begin
            errors++; $display("FAIL full_run done=%b want 1", load_done_a);
        end
        do_reload("full");
    endtask

    task automatic test_wrap();
        logic [7:0] sum;
        int bad = 0;
        clear_log();
        sum = 8'h20;
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            send_byte(8'(i) ^ 8'hA5);
            sum = sum + 8'(i) + (8'(i) ^ 8'hA5);
        end
        send_byte(sum);
        checks++;
        if (wr_addr_b.size() != 32) begin
            errors++; $display("FAIL wrap_count got %0d want 32", wr_addr_b.size());
        end else begin
            for (int i = 0; i < 32; i++)
                if (wr_addr_b[i] !== 8'(8'hF0 + i) || wr_data_b[i] !== {8'(i), 8'(i) ^ 8'hA5}) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL wrap_words got %0d bad entries want 0", bad);
            end
            checks++;
            if (wr_addr_b[16] !== 8'h00) begin
                errors++; $display("FAIL wrap_point got %h want 00", wr_addr_b[16]);
            end
        end
        checks++;
        if (load_done_b !== 1'b1) begin
            errors++; $display("FAIL wrap_run done=%b want 1", load_done_b);
        end
        do_reload("wrap");
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h05); send_byte(8'h02);
        // Now in LOW of the second word; reset between edges.
        reset = 1'b1;
        #2;
        checks++;
        if (in_ready_a !== 1'b1 || cpu_reset_a !== 1'b1 || mem_write_a !== 1'b0 ||
            mem_address_a !== 8'h00 || mem_data_a !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_async rdy=%b crst=%b we=%b addr=%h data=%h want 1 1 0 00 0000",
                     in_ready_a, cpu_reset_a, mem_write_a, mem_address_a, mem_data_a);
        end
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (wr_addr_a.size() != 1 || wr_data_a[0] !== 16'h0005) begin
            errors++; $display("FAIL midreset_writes count=%0d want 1 of 0005", wr_addr_a.size());
        end
        checks++;
        if (in_ready_a !== 1'b1 || cpu_reset_a !== 1'b1 || load_done_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_count rdy=%b crst=%b done=%b want 1 1 0",
                     in_ready_a, cpu_reset_a, load_done_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two();
        test_error();
        test_gappy();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
